// File: rtl/usb_reply_pkg.sv
// Shared constants, FSM state encoding and the round-robin helper used by the
// USB reply arbiter and any later arbiter built on the same selector.
package usb_reply_pkg;

   localparam int REPLY_BYTES_DEFAULT = 3;
   localparam int REPLY_W             = REPLY_BYTES_DEFAULT * 8;
   localparam int RR_MAX              = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   // First set bit of req after 'last', wrapping modulo n; returns last when req is empty.
   // Walks offsets from farthest to nearest so the nearest candidate wins.
   function automatic logic [2:0] rr_next(input logic [RR_MAX-1:0] req,
                                          input logic [2:0]        last,
                                          input int                n);
      logic [2:0] cand;
      rr_next = last;
      for (int off = RR_MAX; off >= 1; off--) begin
         if (off <= n) begin
            cand = 3'((int'(last) + off) % n);
            if (req[cand]) rr_next = cand;
         end
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: chooses the first pending request after
// the last granted index, wrapping around N sources.
module rr_pick
   import usb_reply_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [RR_MAX-1:0] req_pad;
   logic [2:0]        last_pad;

   always_comb begin
      req_pad  = RR_MAX'(req);
      last_pad = 3'(last);
      valid    = |req;
      idx      = IDX_W'(rr_next(req_pad, last_pad, N));
   end

endmodule

// File: rtl/usb_reply_arbiter.sv
// Round-robin arbiter sharing the USB command block's single reply port.
// Optional build macro REPLY_ARB_TAG_EN tags the reply MSBs with the granted source index.
module usb_reply_arbiter
   import usb_reply_pkg::*;
#(
   parameter int NUM_SOURCES = 4,
   parameter int REPLY_BYTES = REPLY_BYTES_DEFAULT,
   parameter int SRC_W       = 2
) (
   input  logic                                 CLK_48,
   input  logic                                 RESET_N,
   input  logic [NUM_SOURCES-1:0]               i_req,
   input  logic [NUM_SOURCES*REPLY_BYTES*8-1:0] i_req_data,
   output logic [NUM_SOURCES-1:0]               o_ack,
   input  logic                                 i_busy,
   output logic                                 o_reply,
   output logic [REPLY_BYTES*8-1:0]             o_data,
   output logic [SRC_W-1:0]                     o_grant_idx
);

   localparam int DATA_W = REPLY_BYTES * 8;

   // Handshake: a source raises i_req[k] with stable data and holds it until it
   // sees the one-cycle o_ack[k]; it must drop i_req[k] on the next cycle, and a
   // request dropped before its ack is simply withdrawn.
   arb_state_t              state, state_nxt;
   logic                    pick_valid;
   logic [SRC_W-1:0]        pick_idx;
   logic [DATA_W-1:0]       pick_data;
   logic                    reply_nxt;
   logic [NUM_SOURCES-1:0]  ack_nxt;
   logic [DATA_W-1:0]       data_nxt;
   logic [SRC_W-1:0]        grant_nxt;

   rr_pick #(
      .N     (NUM_SOURCES),
      .IDX_W (SRC_W)
   ) u_rr_pick (
      .req   (i_req),
      .last  (o_grant_idx),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      pick_data = i_req_data[int'(pick_idx)*DATA_W +: DATA_W];
`ifdef REPLY_ARB_TAG_EN
      pick_data[DATA_W-1 -: SRC_W] = pick_idx;
`endif
   end

   // GUARD skips one busy sample because the flag lags acceptance by a cycle.
   always_comb begin
      state_nxt = state;
      reply_nxt = 1'b0;
      ack_nxt   = '0;
      data_nxt  = o_data;
      grant_nxt = o_grant_idx;
      case (state)
         IDLE: begin
            if (pick_valid && !i_busy) begin
               reply_nxt = 1'b1;
               ack_nxt   = NUM_SOURCES'(1) << pick_idx;
               data_nxt  = pick_data;
               grant_nxt = pick_idx;
               state_nxt = GUARD;
            end
         end
         GUARD:   state_nxt = WAIT;
         WAIT:    if (!i_busy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_48 or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         o_reply     <= 1'b0;
         o_ack       <= '0;
         o_data      <= '0;
         o_grant_idx <= SRC_W'(NUM_SOURCES - 1);
      end else begin
         state       <= state_nxt;
         o_reply     <= reply_nxt;
         o_ack       <= ack_nxt;
         o_data      <= data_nxt;
         o_grant_idx <= grant_nxt;
      end
   end

endmodule
